// File: rtl/traffic_phase_controller.sv
// Two-road intersection phase sequencer with an optional pedestrian walk phase.
// Each phase is timed in whole 1 s ticks; lamp outputs are registered Moore decodes.
module traffic_phase_controller #(
    parameter int GREEN_S  = 10,
    parameter int YELLOW_S = 3,
    parameter int ALLRED_S = 1,
    parameter int WALK_S   = 5,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             enable,
    input  logic             ped_req,
    output logic             ped_ack,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic             walk,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] sec_left
);

    typedef enum logic [2:0] {
        S_ALLRED_A  = 3'd0,
        S_NS_GREEN  = 3'd1,
        S_NS_YELLOW = 3'd2,
        S_ALLRED_B  = 3'd3,
        S_EW_GREEN  = 3'd4,
        S_EW_YELLOW = 3'd5,
        S_WALK      = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_t state, nxt;
    logic   ped_pending;
    logic   ret_ns;      // 1: WALK returns to NS_GREEN, 0: to EW_GREEN
    logic   run;
    logic   expire;
    logic   enter_walk;

    // Countdown load value; a zero duration is treated as one tick.
    function automatic logic [CNT_W-1:0] load_val(input state_t s);
        int d;
        case (s)
            S_NS_GREEN, S_EW_GREEN:   d = GREEN_S;
            S_NS_YELLOW, S_EW_YELLOW: d = YELLOW_S;
            S_WALK:                   d = WALK_S;
            default:                  d = ALLRED_S;
        endcase
        return (d <= 1) ? '0 : CNT_W'(d - 1);
    endfunction

    // Lamp decode {ns, ew} as a pure function of state.
    function automatic logic [5:0] lamps(input state_t s);
        case (s)
            S_NS_GREEN:  return {LAMP_G, LAMP_R};
            S_NS_YELLOW: return {LAMP_Y, LAMP_R};
            S_EW_GREEN:  return {LAMP_R, LAMP_G};
            S_EW_YELLOW: return {LAMP_R, LAMP_Y};
            default:     return {LAMP_R, LAMP_R};
        endcase
    endfunction

    // Next-state selection; ped_pending is the pre-update value, so a request
    // first seen on an ALLRED expiry clock waits for the next ALLRED.
    always_comb begin
        run    = tick && enable;
        expire = run && (sec_left == '0);
        nxt    = state;
        case (state)
            S_ALLRED_A:  if (expire) nxt = ped_pending ? S_WALK : S_NS_GREEN;
            S_NS_GREEN:  if (expire) nxt = S_NS_YELLOW;
            S_NS_YELLOW: if (expire) nxt = S_ALLRED_B;
            S_ALLRED_B:  if (expire) nxt = ped_pending ? S_WALK : S_EW_GREEN;
            S_EW_GREEN:  if (expire) nxt = S_EW_YELLOW;
            S_EW_YELLOW: if (expire) nxt = S_ALLRED_A;
            S_WALK:      if (expire) nxt = ret_ns ? S_NS_GREEN : S_EW_GREEN;
            default:     nxt = S_ALLRED_A;
        endcase
        enter_walk = (nxt == S_WALK) && (state != S_WALK);
    end

    // State, countdown, pedestrian bookkeeping and registered lamp outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_ALLRED_A;
            sec_left    <= load_val(S_ALLRED_A);
            ped_pending <= 1'b0;
            ret_ns      <= 1'b0;
            ped_ack     <= 1'b0;
            walk        <= 1'b0;
            ns_light    <= LAMP_R;
            ew_light    <= LAMP_R;
        end else begin
            state <= nxt;
            // No phase loops onto itself, so a state change always means a new phase.
            if (nxt != state)
                sec_left <= load_val(nxt);
            else if (run)
                sec_left <= sec_left - 1'b1;

            if (expire && state == S_ALLRED_A) ret_ns <= 1'b1;
            if (expire && state == S_ALLRED_B) ret_ns <= 1'b0;

            if (enter_walk)
                ped_pending <= 1'b0;
            else if (ped_req && state != S_WALK)
                ped_pending <= 1'b1;

            ped_ack                <= enter_walk;
            walk                   <= (nxt == S_WALK);
            {ns_light, ew_light}   <= lamps(nxt);
        end
    end

    assign phase = state;

endmodule
